md5_round3_unstep: RTL and testbench
====================================

# md5_round3_unstep

Iterative inverse of MD5 round 3. Given the chaining state leaving round 3 (after step 47) and the 512-bit message block, it undoes the 16 round-3 steps, one step per clock. It returns the state that entered round 3 (before step 32). It sits beside the forward `round3` datapath in the hashing-optimization flow and serves meet-in-the-middle and search-pruning engines that need to walk state backward from a target.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `a_in`, `b_in`, `c_in`, `d_in`  in  32 each  state after round-3 step 15 (global step 47).
- `msg_blk`  in  512  message block; word j = `msg_blk[32j+31:32j]`.
- `busy`  out  1  high while steps are executing.
- `done`  out  1  one-cycle pulse when the result is valid.
- `a_out`, `b_out`, `c_out`, `d_out`  out  32 each  recovered round-3 entry state; held until next accepted start.

## Operation
- Forward round-3 step i (i = 0..15), as implemented elsewhere:
  - H = b^c^d
  - new = b + rotl(a + H + X[k] + T[i], s)
  - (a,b,c,d) <- (d, new, b, c)
- Inverse step i, with registered state (a',b',c',d'):
  - b = c', c = d', d = a'
  - a = rotr(b' - b, s) - (b^c^d) - X[k] - T[i]
  - next state = (a,b,c,d)
- All arithmetic is mod 2^32. Subtraction wraps and there is no overflow flag. rotr is a rotate, not a shift.
- Steps execute in order i = 15, 14, ..., 0.
- k = (5 + 3i) mod 16.
- s = 4, 11, 16, 23 for i mod 4 = 0, 1, 2, 3.
- T[0..15], held in an internal ROM:
  - fffa3942, 8771f681, 6d9d6122, fde5380c
  - a4beea44, 4bdecfa9, f6bb4b60, bebfbc70
  - 289b7ec6, eaa127fa, d4ef3085, 04881d05
  - d9d4d039, e6db99e5, 1fa27cf8, c4ac5665
- `msg_blk` is latched at start. Later changes to the inputs do not affect a run in progress.
- FSM:
  - IDLE: `start` -> RUN. Latch the state inputs and `msg_blk`; set step counter = 15.
  - RUN: perform one inverse step per cycle and decrement the counter. After the step with counter = 0 -> DONE.
  - DONE: one cycle. `done`=1, `busy`=0, outputs valid. Then -> IDLE, or directly -> RUN if `start`=1 in that cycle.
- `start` while `busy`=1 is ignored. No queueing, no error.

## Timing
- Reset (async assert, any state):
  - FSM -> IDLE
  - `busy`=0, `done`=0
  - all outputs and internal state registers = 0
  - counter = 15
- Reset release is synchronous to `clk`.
- Reset mid-RUN abandons the run. Outputs stay 0 and no `done` pulse is produced.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 after E0 through E16.
  - Steps occur at edges E1..E16.
  - `done`=1 and outputs valid after E16, for exactly one cycle.
  - `done` falls after E17.
- Throughput: one block per 17 cycles; back-to-back is possible via `start` during DONE.
- Outputs change only at the DONE transition. During RUN they hold the previous result.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 asynchronously mid-cycle.
  - Required: all outputs 0 before the next edge. Then release, start a run with any data, and pull reset at step 7 -> FSM returns to IDLE, no `done` pulse, outputs remain 0.
- Round trip, standard IV:
  - Stimulus: a golden forward model runs round 3 from (67452301, efcdab89, 98badcfe, 10325476) on `msg_blk` = words 0..15 = 0..15. Its output is applied as `a_in`..`d_in`.
  - Required: `done` 16 cycles after the start edge, with exactly that IV on `a_out`..`d_out`.
- Zero vector:
  - Stimulus: all inputs 0, `msg_blk`=0.
  - Required: result equals the golden inverse-model value, and the forward model applied to the result returns all-zero state.
- Busy handling:
  - Stimulus: pulse `start` at steps 3 and 10 of a run with different data.
  - Required: both pulses ignored, first result unchanged, exactly one `done` pulse.
- Back-to-back:
  - Stimulus: hold `start`=1 continuously with two different blocks.
  - Required: `done` pulses 17 cycles apart, each result matching its own block. The `busy` gap is one cycle.
- Random:
  - Stimulus: 1000 random states and blocks through forward model -> DUT.
  - Required: 100% round-trip match, covering wrap-around on every subtraction.

Source files
------------

// File: rtl/md5_round3_unstep.sv
// Iterative inverse of MD5 round 3: walks the chaining state back from step 47
// to the round-3 entry state (before step 32), one step per clock.
module md5_round3_unstep (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [31:0]  a_in,
   input  logic [31:0]  b_in,
   input  logic [31:0]  c_in,
   input  logic [31:0]  d_in,
   input  logic [511:0] msg_blk,
   output logic         busy,
   output logic         done,
   output logic [31:0]  a_out,
   output logic [31:0]  b_out,
   output logic [31:0]  c_out,
   output logic [31:0]  d_out
);

   localparam int unsigned W  = 32;
   localparam int unsigned MW = 512;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        st;
   logic [W-1:0]  a_r, b_r, c_r, d_r;
   logic [MW-1:0] msg_r;
   logic [CW-1:0] cnt;

   logic [CW-1:0] k_c;
   logic [SW-1:0] s_c;
   logic [W-1:0]  t_c;
   logic [W-1:0]  x_c;
   logic [W-1:0]  diff_c;
   logic [W-1:0]  rot_c;
   logic [W-1:0]  na_c;

   // One inverse step for the step index held in cnt
   always_comb begin
      k_c    = CW'(32'd5 + 32'd3 * 32'(cnt));
      s_c    = SW'(4);
      t_c    = '0;
      case (cnt[1:0])
         2'd0:    s_c = SW'(4);
         2'd1:    s_c = SW'(11);
         2'd2:    s_c = SW'(16);
         default: s_c = SW'(23);
      endcase
      case (cnt)
         4'd0:    t_c = 32'hfffa3942;
         4'd1:    t_c = 32'h8771f681;
         4'd2:    t_c = 32'h6d9d6122;
         4'd3:    t_c = 32'hfde5380c;
         4'd4:    t_c = 32'ha4beea44;
         4'd5:    t_c = 32'h4bdecfa9;
         4'd6:    t_c = 32'hf6bb4b60;
         4'd7:    t_c = 32'hbebfbc70;
         4'd8:    t_c = 32'h289b7ec6;
         4'd9:    t_c = 32'heaa127fa;
         4'd10:   t_c = 32'hd4ef3085;
         4'd11:   t_c = 32'h04881d05;
         4'd12:   t_c = 32'hd9d4d039;
         4'd13:   t_c = 32'he6db99e5;
         4'd14:   t_c = 32'h1fa27cf8;
         default: t_c = 32'hc4ac5665;
      endcase
      x_c    = msg_r[{k_c, 5'd0} +: W];
      // Recovered b is the registered c; rotate-right via doubled word
      diff_c = b_r - c_r;
      rot_c  = W'({diff_c, diff_c} >> s_c);
      na_c   = rot_c - (c_r ^ d_r ^ a_r) - x_c - t_c;
   end

   // Control FSM, working state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= CW'(15);
         a_r   <= '0;
         b_r   <= '0;
         c_r   <= '0;
         d_r   <= '0;
         msg_r <= '0;
         a_out <= '0;
         b_out <= '0;
         c_out <= '0;
         d_out <= '0;
      end else begin
         case (st)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= a_in;
                  b_r   <= b_in;
                  c_r   <= c_in;
                  d_r   <= d_in;
                  msg_r <= msg_blk;
                  cnt   <= CW'(15);
                  busy  <= 1'b1;
                  st    <= ST_RUN;
               end else begin
                  st    <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_r <= na_c;
               b_r <= c_r;
               c_r <= d_r;
               d_r <= a_r;
               cnt <= CW'(cnt - 4'd1);
               if (cnt == '0) begin
                  a_out <= na_c;
                  b_out <= c_r;
                  c_out <= d_r;
                  d_out <= a_r;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  st    <= ST_DONE;
               end
            end
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
               st   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_round3_unstep.sv
// Directed and random round-trip bench for md5_round3_unstep against a
// behavioural forward/inverse round-3 model with a per-cycle output checker.
module tb_md5_round3_unstep;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } st_t;

   typedef struct {
      int  sc;
      st_t exp;
   } job_t;

   localparam logic [31:0] TT [16] = '{
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665};
   localparam int SH [4] = '{4, 11, 16, 23};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [31:0]  a_in, b_in, c_in, d_in;
   logic [511:0] msg_blk;
   logic         busy, done;
   logic [31:0]  a_out, b_out, c_out, d_out;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   job_t q[$];
   st_t  hold = '0;

   md5_round3_unstep dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
      .msg_blk(msg_blk), .busy(busy), .done(done),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic st_t fwd_step(st_t s, logic [511:0] m, int i);
      st_t r;
      int k = (5 + 3 * i) % 16;
      int sh = SH[i % 4];
      logic [31:0] t;
      t = s.a + (s.b ^ s.c ^ s.d) + m[32*k +: 32] + TT[i];
      r.a = s.d;
      r.b = s.b + ((t << sh) | (t >> (32 - sh)));
      r.c = s.b;
      r.d = s.c;
      return r;
   endfunction

   function automatic st_t fwd(st_t s, logic [511:0] m);
      st_t r = s;
      for (int i = 0; i < 16; i++) r = fwd_step(r, m, i);
      return r;
   endfunction

   function automatic st_t inv_step(st_t s, logic [511:0] m, int i);
      st_t r;
      int k = (5 + 3 * i) % 16;
      int sh = SH[i % 4];
      logic [31:0] x;
      r.b = s.c;
      r.c = s.d;
      r.d = s.a;
      x = s.b - r.b;
      r.a = ((x >> sh) | (x << (32 - sh))) - (r.b ^ r.c ^ r.d) - m[32*k +: 32] - TT[i];
      return r;
   endfunction

   function automatic st_t inv(st_t s, logic [511:0] m);
      st_t r = s;
      for (int i = 15; i >= 0; i--) r = inv_step(r, m, i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle checker: done/busy timing and output contents against the scoreboard
   always @(negedge clk) begin
      st_t act;
      if (rst_n) begin
         act = {a_out, b_out, c_out, d_out};
         if (q.size() > 0 && cyc == q[0].sc + 16) begin
            chk("done_pulse", 128'(done), 128'(1));
            chk("busy_at_done", 128'(busy), 128'(0));
            chk("result", act, q[0].exp);
            hold = q[0].exp;
            void'(q.pop_front());
         end else begin
            chk("done_low", 128'(done), 128'(0));
            chk("busy", 128'(busy),
                128'(q.size() > 0 && cyc >= q[0].sc && cyc < q[0].sc + 16));
            chk("held_output", act, hold);
         end
      end
   end

   task automatic push_job(input int sc, input st_t exp);
      job_t j;
      j.sc  = sc;
      j.exp = exp;
      q.push_back(j);
   endtask

   // Start a run; returns one time unit after the start edge with inputs scrambled
   task automatic go(input st_t s, input logic [511:0] m, input st_t exp);
      @(posedge clk); #1;
      {a_in, b_in, c_in, d_in} = s;
      msg_blk = m;
      start = 1'b1;
      push_job(cyc + 1, exp);
      @(posedge clk); #1;
      start = 1'b0;
      {a_in, b_in, c_in, d_in} = ~s;
      msg_blk = ~m;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: %0d result(s) still pending, expected 0", q.size());
         q.delete();
      end
      @(negedge clk); #1;
   endtask

   task automatic hit_reset();
      rst_n = 1'b0;
      q.delete();
      hold = '0;
      #1;
      chk("rst_outputs", {a_out, b_out, c_out, d_out}, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      st_t          iv, e, z, tmp;
      logic [511:0] m, ma, mb;

      rst_n = 1'b0;
      start = 1'b0;
      {a_in, b_in, c_in, d_in} = '0;
      msg_blk = '0;
      #3;
      chk("reset_outputs", {a_out, b_out, c_out, d_out}, 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_done", 128'(done), 128'(0));

      // Hand-worked single steps that pin the model
      tmp = fwd_step('0, '0, 0);
      chk("model_fwd_i0", 128'(tmp.b), 128'(32'hffa3942f));
      tmp = fwd_step('0, '0, 1);
      chk("model_fwd_i1", 128'(tmp.b), 128'(32'h8fb40c3b));
      tmp = inv_step('{a: 32'h0, b: 32'hffa3942f, c: 32'h0, d: 32'h0}, '0, 0);
      chk("model_inv_i0", tmp, 128'(0));

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Standard IV round trip, words 0..15 = 0..15
      iv = '{a: 32'h67452301, b: 32'hefcdab89, c: 32'h98badcfe, d: 32'h10325476};
      for (int j = 0; j < 16; j++) m[32*j +: 32] = 32'(j);
      go(fwd(iv, m), m, iv);
      wait_idle();

      // All-zero vector
      z = inv('0, '0);
      go('0, '0, z);
      wait_idle();
      chk("zero_fwd_back", fwd({a_out, b_out, c_out, d_out}, '0), 128'(0));

      // Async reset mid-cycle, then reset at step 7 of a run
      @(posedge clk); #3;
      hit_reset();
      go(fwd(iv, m), m, iv);
      repeat (6) @(posedge clk);
      #2;
      hit_reset();
      repeat (30) @(posedge clk);

      // Start pulses during a run are ignored
      e = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 16; j++) ma[32*j +: 32] = $urandom;
      for (int j = 0; j < 16; j++) mb[32*j +: 32] = $urandom;
      go(fwd(e, ma), ma, e);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; {a_in, b_in, c_in, d_in} = ~e; msg_blk = mb;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #1 start = 1'b1; {a_in, b_in, c_in, d_in} = e; msg_blk = mb;
      @(posedge clk); #1 start = 1'b0;
      wait_idle();

      // Back-to-back with start held high
      iv = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      {a_in, b_in, c_in, d_in} = fwd(e, ma);
      msg_blk = ma;
      start = 1'b1;
      push_job(cyc + 1, e);
      @(posedge clk); #1;
      {a_in, b_in, c_in, d_in} = fwd(iv, mb);
      msg_blk = mb;
      push_job(q[q.size()-1].sc + 17, iv);
      repeat (17) @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // Random round trips
      for (int n = 0; n < 1000; n++) begin
         e = {$urandom, $urandom, $urandom, $urandom};
         for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
         go(fwd(e, m), m, e);
         wait_idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
